// File: rtl/iddr_tap_cal.sv
// IDDR input-delay tap calibration.
// Sweeps a shared delay tap across all lanes from 0 to MAX_TAP, scoring each
// tap by comparing captured rising/falling bits against a fixed training
// pattern. For every lane it then loads the centre of the longest passing
// window (lowest-tap window wins ties). Lanes whose window is shorter than
// MIN_EYE are flagged and parked at tap 0.
module iddr_tap_cal #(
  parameter int   WIDTH         = 4,
  parameter int   TAP_WIDTH     = 9,
  parameter int   MAX_TAP       = 511,
  parameter int   SETTLE_CYCLES = 8,
  parameter int   SAMPLE_CYCLES = 16,
  parameter logic PAT_Q1        = 1'b1,
  parameter logic PAT_Q2        = 1'b0,
  parameter int   MIN_EYE       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       rdy_idelay,
  input  logic [WIDTH-1:0]           q1,
  input  logic [WIDTH-1:0]           q2,
  output logic                       load,
  output logic [WIDTH*TAP_WIDTH-1:0] cnt_value_in,
  output logic                       en_vtc,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           error
);

  // Run lengths must reach MAX_TAP+1 when a lane passes every tap.
  localparam int RUN_W   = $clog2(MAX_TAP + 2);
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    SET_TAP  = 3'd2,
    SETTLE   = 3'd3,
    SAMPLE   = 3'd4,
    EVAL     = 3'd5,
    CENTER   = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t state, state_nxt;

  logic [TAP_WIDTH-1:0]       tap;
  logic [CNT_W-1:0]           cnt;
  logic [WIDTH-1:0]           pass;
  logic [WIDTH-1:0]           match;
  logic [WIDTH-1:0]           err_q;
  logic [WIDTH-1:0]           err_w;
  logic [WIDTH*TAP_WIDTH-1:0] hold_q;
  logic [WIDTH*TAP_WIDTH-1:0] center_w;
  logic [WIDTH*TAP_WIDTH-1:0] sweep_w;

  logic [RUN_W-1:0]     run_len    [WIDTH];
  logic [TAP_WIDTH-1:0] run_start  [WIDTH];
  logic [RUN_W-1:0]     best_len   [WIDTH];
  logic [TAP_WIDTH-1:0] best_start [WIDTH];
  logic [RUN_W-1:0]     eval_len   [WIDTH];
  logic [TAP_WIDTH-1:0] eval_start [WIDTH];
  logic [RUN_W-1:0]     half       [WIDTH];

  logic settle_last;
  logic sample_last;
  logic tap_last;

  assign settle_last = (cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign sample_last = (cnt == CNT_W'(SAMPLE_CYCLES - 1));
  assign tap_last    = (tap == TAP_WIDTH'(MAX_TAP));
  assign sweep_w     = {WIDTH{tap}};
  assign error       = err_q;

  // State register; reset aborts any calibration in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is honoured only when idle or finished.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)       state_nxt = WAIT_RDY;
      WAIT_RDY:   if (rdy_idelay)  state_nxt = SET_TAP;
      SET_TAP:                     state_nxt = SETTLE;
      SETTLE:     if (settle_last) state_nxt = SAMPLE;
      SAMPLE:     if (sample_last) state_nxt = EVAL;
      EVAL:       state_nxt = tap_last ? CENTER : SET_TAP;
      CENTER:                      state_nxt = DONE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Per-lane pattern match, run extension and window centre arithmetic.
  always_comb begin
    match      = '0;
    err_w      = '0;
    center_w   = '0;
    eval_len   = '{default: '0};
    eval_start = '{default: '0};
    half       = '{default: '0};
    for (int i = 0; i < WIDTH; i++) begin
      match[i]      = (q1[i] == PAT_Q1) && (q2[i] == PAT_Q2);
      eval_len[i]   = run_len[i] + 1'b1;
      eval_start[i] = (run_len[i] == '0) ? tap : run_start[i];
      half[i]       = (best_len[i] - 1'b1) >> 1;
      if (int'(best_len[i]) < MIN_EYE) begin
        err_w[i] = 1'b1;
      end else begin
        center_w[i*TAP_WIDTH +: TAP_WIDTH] = best_start[i] + TAP_WIDTH'(half[i]);
      end
    end
  end

  // Sweep bookkeeping: tap/phase counters, pass flags, run trackers, results.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap    <= '0;
      cnt    <= '0;
      pass   <= '0;
      err_q  <= '0;
      hold_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        run_len[i]    <= '0;
        run_start[i]  <= '0;
        best_len[i]   <= '0;
        best_start[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
              run_len[i]    <= '0;
              run_start[i]  <= '0;
              best_len[i]   <= '0;
              best_start[i] <= '0;
            end
          end
        end
        WAIT_RDY: if (rdy_idelay) tap <= '0;
        SET_TAP:  cnt <= '0;
        SETTLE: begin
          if (settle_last) begin
            cnt  <= '0;
            pass <= '1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          pass <= pass & match;
          cnt  <= cnt + 1'b1;
        end
        EVAL: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (pass[i]) begin
              run_len[i]   <= eval_len[i];
              run_start[i] <= eval_start[i];
              // Strictly longer only, so the earliest of equal windows stays.
              if (eval_len[i] > best_len[i]) begin
                best_len[i]   <= eval_len[i];
                best_start[i] <= eval_start[i];
              end
            end else begin
              run_len[i] <= '0;
            end
          end
          if (!tap_last) tap <= tap + 1'b1;
        end
        CENTER: begin
          hold_q <= center_w;
          err_q  <= err_w;
        end
        default: ;
      endcase
    end
  end

  // Output decode; the tap bus shows the sweep tap while sweeping and the
  // final centres once calibration has finished.
  always_comb begin
    load         = 1'b0;
    busy         = 1'b1;
    en_vtc       = 1'b0;
    done         = 1'b0;
    cnt_value_in = hold_q;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        en_vtc = 1'b1;
      end
      DONE: begin
        busy   = 1'b0;
        en_vtc = 1'b1;
        done   = 1'b1;
      end
      SET_TAP: begin
        load         = 1'b1;
        cnt_value_in = sweep_w;
      end
      SETTLE, SAMPLE, EVAL: cnt_value_in = sweep_w;
      CENTER: begin
        load         = 1'b1;
        cnt_value_in = center_w;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iddr_tap_cal.sv
// Bench for iddr_tap_cal: an emulated delay line feeds training data per tap,
// and a timeline model predicts every output cycle by cycle.
module tb_iddr_tap_cal;

  localparam int WIDTH   = 2;
  localparam int TW      = 5;
  localparam int MAX_TAP = 31;
  localparam int NTAP    = MAX_TAP + 1;
  localparam int SETTLE  = 2;
  localparam int SAMPLE  = 4;
  localparam int MIN_EYE = 4;
  localparam int PER_TAP = SETTLE + SAMPLE + 2;
  localparam logic PQ1   = 1'b1;
  localparam logic PQ2   = 1'b0;

  logic                clk;
  logic                rst;
  logic                start;
  logic                rdy_idelay;
  logic [WIDTH-1:0]    q1;
  logic [WIDTH-1:0]    q2;
  logic                load;
  logic [WIDTH*TW-1:0] cnt_value_in;
  logic                en_vtc;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    error;

  iddr_tap_cal #(
    .WIDTH(WIDTH), .TAP_WIDTH(TW), .MAX_TAP(MAX_TAP),
    .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE),
    .PAT_Q1(PQ1), .PAT_Q2(PQ2), .MIN_EYE(MIN_EYE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rdy_idelay(rdy_idelay),
    .q1(q1), .q2(q2), .load(load), .cnt_value_in(cnt_value_in),
    .en_vtc(en_vtc), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Training environment: which taps each lane passes, and an optional
  // single-cycle corruption of lane 0 while sampling tap 12.
  bit [31:0] eye [WIDTH];
  bit        glitch_en;

  // Emulated delay line: takes the tap on each load pulse and serves data.
  initial begin : delay_line
    int          cur_tap [WIDTH];
    int          since;
    logic        pl;
    logic [WIDTH*TW-1:0] pv;
    bit          ok;
    q1 = '0;
    q2 = '0;
    cur_tap = '{default: 0};
    since = 0;
    forever begin
      @(negedge clk);
      pl = load;
      pv = cnt_value_in;
      @(posedge clk);
      #1;
      if (pl === 1'b1) begin
        for (int i = 0; i < WIDTH; i++) cur_tap[i] = int'(pv[i*TW +: TW]);
        since = 0;
      end else begin
        since++;
      end
      for (int i = 0; i < WIDTH; i++) begin
        ok = eye[i][cur_tap[i]];
        if (glitch_en && i == 0 && cur_tap[0] == 12 && since == 3) ok = 1'b0;
        // Even lanes fail on the rising bit, odd lanes on the falling bit.
        q1[i] = (ok || (i % 2 == 1)) ? PQ1 : ~PQ1;
        q2[i] = (ok || (i % 2 == 0)) ? PQ2 : ~PQ2;
      end
    end
  end

  // Expected result for one lane: scan every start tap for the longest
  // consecutive pass window, earliest wins on equal length.
  function automatic void calc(input bit [31:0] p, output int c, output bit e);
    int bl;
    int bs;
    bl = 0;
    bs = 0;
    for (int s = 0; s < NTAP; s++) begin
      int l;
      l = 0;
      while ((s + l) < NTAP && p[s + l]) l++;
      if (l > bl) begin
        bl = l;
        bs = s;
      end
    end
    if (bl < MIN_EYE) begin
      e = 1'b1;
      c = 0;
    end else begin
      e = 1'b0;
      c = bs + (bl - 1) / 2;
    end
  endfunction

  int       exp_center [WIDTH];
  bit       exp_err    [WIDTH];
  int       mode = -1;   // -1 unknown, 0 idle, 1 waiting for ready, 2 sweeping, 3 done
  int       k    = 0;    // cycle index within the sweep; NTAP*PER_TAP is the centring load

  function automatic logic [31:0] packed_centers();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v = v | (32'(exp_center[i]) << (i * TW));
    return v;
  endfunction

  function automatic logic [31:0] packed_err();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v[i] = exp_err[i];
    return v;
  endfunction

  // Cycle-by-cycle compare against the timeline model.
  initial begin : compare
    bit [31:0] p;
    int        t;
    forever begin
      @(negedge clk);
      case (mode)
        0: begin
          check("idle_load", load, 0);
          check("idle_busy", busy, 0);
          check("idle_done", done, 0);
          check("idle_en_vtc", en_vtc, 1);
          check("idle_cnt", cnt_value_in, 0);
          check("idle_error", error, 0);
        end
        1: begin
          check("wait_load", load, 0);
          check("wait_busy", busy, 1);
          check("wait_done", done, 0);
          check("wait_en_vtc", en_vtc, 0);
          check("wait_error", error, 0);
        end
        2: begin
          check("sweep_busy", busy, 1);
          check("sweep_done", done, 0);
          check("sweep_en_vtc", en_vtc, 0);
          check("sweep_error", error, 0);
          if (k == NTAP * PER_TAP) begin
            check("center_load", load, 1);
            check("center_cnt", cnt_value_in, packed_centers());
          end else begin
            check("sweep_load", load, (k % PER_TAP == 0) ? 1 : 0);
            if (k % PER_TAP == 0) begin
              t = k / PER_TAP;
              check("sweep_tap", cnt_value_in, 32'(t) | (32'(t) << TW));
            end
          end
        end
        3: begin
          check("done_load", load, 0);
          check("done_busy", busy, 0);
          check("done_done", done, 1);
          check("done_en_vtc", en_vtc, 1);
          check("done_cnt", cnt_value_in, packed_centers());
          check("done_error", error, packed_err());
        end
        default: ;
      endcase
      if (rst === 1'b1) begin
        mode = 0;
      end else begin
        case (mode)
          0, 3: if (start === 1'b1) begin
            mode = 1;
            for (int i = 0; i < WIDTH; i++) begin
              p = eye[i];
              if (glitch_en && i == 0) p[12] = 1'b0;
              calc(p, exp_center[i], exp_err[i]);
            end
          end
          1: if (rdy_idelay === 1'b1) begin
            mode = 2;
            k = 0;
          end
          2: if (k == NTAP * PER_TAP) mode = 3; else k++;
          default: ;
        endcase
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 600) begin
      cyc(1);
      n++;
    end
    check(name, done, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int loads;
    rst        = 1'b1;
    start      = 1'b0;
    rdy_idelay = 1'b1;
    glitch_en  = 1'b0;
    eye[0]     = 32'h0;
    eye[1]     = 32'h0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("reset_busy", busy, 0);
    check("reset_en_vtc", en_vtc, 1);
    check("reset_done", done, 0);
    check("reset_load", load, 0);
    check("reset_cnt", cnt_value_in, 0);
    check("reset_error", error, 0);

    // Lane 0 passes taps 10..19, lane 1 everything; a stray start and a
    // ready drop mid-sweep must both be ignored.
    eye[0] = 32'h000F_FC00;
    eye[1] = 32'hFFFF_FFFF;
    pulse_start();
    cyc(40);
    pulse_start();
    rdy_idelay = 1'b0;
    wait_done("t1_done");
    check("t1_model_c0", exp_center[0], 14);
    check("t1_model_c1", exp_center[1], 15);
    check("t1_cnt", cnt_value_in, 15 * 32 + 14);
    check("t1_error", error, 0);

    // Two equal windows 3..6 and 20..23; restart directly from done.
    rdy_idelay = 1'b1;
    eye[0] = 32'h00F0_0078;
    pulse_start();
    check("t2_done_cleared", done, 0);
    wait_done("t2_done");
    check("t2_model_c0", exp_center[0], 4);
    check("t2_cnt", cnt_value_in, 15 * 32 + 4);
    check("t2_error", error, 0);

    // Glitch at tap 12 splits lane 0; lane 1 window 5..7 is too small.
    eye[0]    = 32'h000F_FC00;
    eye[1]    = 32'h0000_00E0;
    glitch_en = 1'b1;
    pulse_start();
    wait_done("t3_done");
    check("t3_model_c0", exp_center[0], 16);
    check("t3_model_e1", exp_err[1], 1);
    check("t3_cnt", cnt_value_in, 16);
    check("t3_error", error, 2);
    glitch_en = 1'b0;

    // Ready held low: no load pulses, VT compensation off.
    eye[0]     = 32'h000F_FC00;
    eye[1]     = 32'hFFFF_FFFF;
    rdy_idelay = 1'b0;
    pulse_start();
    loads = 0;
    for (int i = 0; i < 50; i++) begin
      if (load === 1'b1) loads++;
      cyc(1);
    end
    check("t4_no_load", loads, 0);
    check("t4_en_vtc", en_vtc, 0);
    check("t4_busy", busy, 1);
    rdy_idelay = 1'b1;

    // Abort with reset while sampling tap 9.
    n = 0;
    while (!(load === 1'b1 && cnt_value_in[TW-1:0] == 5'd9) && n < 200) begin
      cyc(1);
      n++;
    end
    check("t4_reach_tap9", (n < 200) ? 1 : 0, 1);
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t4_abort_busy", busy, 0);
    check("t4_abort_en_vtc", en_vtc, 1);
    check("t4_abort_cnt", cnt_value_in, 0);
    pulse_start();
    wait_done("t4_recal_done");
    check("t4_recal_cnt", cnt_value_in, 15 * 32 + 14);
    check("t4_recal_error", error, 0);

    // Reset and start together: reset wins, start is lost.
    rst   = 1'b1;
    start = 1'b1;
    cyc(1);
    rst   = 1'b0;
    start = 1'b0;
    check("t5_done", done, 0);
    check("t5_busy", busy, 0);
    cyc(2);
    check("t5_still_idle", busy, 0);
    check("t5_en_vtc", en_vtc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
